// File: rtl/uart_rx.sv
// uart_rx: 8N-with-parity UART receiver with parity/framing checks and a byte FIFO
// drained through a level Receive / pulse Received handshake.
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 19200,
    parameter bit PARITY_ODD = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Sin,
    output logic       Receive,
    input  logic       Received,
    output logic [7:0] Dout,
    output logic       parityErr,
    output logic       framingErr,
    output logic       overrun
);
    localparam int BIT_TICKS = CLK_FREQ / BAUD;
    localparam int CW = $clog2(BIT_TICKS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_END = CW'(BIT_TICKS / 2 - 1);
    localparam logic [CW-1:0] BIT_END = CW'(BIT_TICKS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    data;
    logic          bad;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wp, rp;
    logic          full, empty, push, pop;

    assign s = sync[1];
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign push = state == STOP && cnt == BIT_END && s;
    assign pop = Received && !empty;
    assign Receive = !empty;
    assign {parityErr, Dout} = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync <= 2'b11;
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            data <= '0;
            bad <= 1'b0;
            framingErr <= 1'b0;
        end else begin
            sync <= {sync[0], Sin};
            framingErr <= 1'b0;
            cnt <= cnt + 1'b1;
            case (state)
                IDLE: if (!s) begin
                    state <= START;
                    cnt <= '0;
                end
                START: if (cnt == HALF_END) begin
                    cnt <= '0;
                    idx <= '0;
                    state <= s ? IDLE : DATA;
                end
                DATA: if (cnt == BIT_END) begin
                    cnt <= '0;
                    data[idx] <= s;
                    idx <= idx + 1'b1;
                    if (idx == 3'd7) state <= PARITY;
                end
                PARITY: if (cnt == BIT_END) begin
                    cnt <= '0;
                    bad <= (^data ^ s) != PARITY_ODD;
                    state <= STOP;
                end
                // A low stop bit means a broken frame or a break; wait for the line to recover.
                STOP: if (cnt == BIT_END) begin
                    cnt <= '0;
                    framingErr <= !s;
                    state <= s ? IDLE : BREAK;
                end
                BREAK: if (s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A push into a full FIFO succeeds only when a pop frees the head slot in the same cycle.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wp <= '0;
            rp <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push && (!full || pop)) begin
                mem[wp[AW-1:0]] <= {bad, data};
                wp <= wp + 1'b1;
            end
            if (push && full && !pop) overrun <= 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed frames against a queue-based scoreboard; a monitor
// pops expectations whenever the consumer acknowledges a presented byte.
module tb_uart_rx;
    localparam int BT = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Sin = 1'b1;
    logic       ack_en = 1'b0;
    logic       Receive, Received, parityErr, framingErr, overrun;
    logic [7:0] Dout;

    int         checks = 0;
    int         failures = 0;
    int         fe_count = 0;
    int         exp_fe = 0;
    logic       exp_overrun = 1'b0;
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    // Behaves like the command decoder: acknowledge a byte in the cycle it appears.
    assign Received = ack_en && Receive;

    uart_rx #(
        .CLK_FREQ(1_600_000),
        .BAUD(100_000),
        .PARITY_ODD(1),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .Reset(Reset),
        .Sin(Sin),
        .Receive(Receive),
        .Received(Received),
        .Dout(Dout),
        .parityErr(parityErr),
        .framingErr(framingErr),
        .overrun(overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ~^d;
    endfunction

    // Reference model: odd parity means data ones plus parity bit must be odd.
    task automatic expect_frame(input logic [7:0] d, input logic p, input logic st);
        logic bad;
        bad = (($countones(d) + int'(p)) % 2) == 0;
        if (!st) exp_fe++;
        else if (ack_en || exp_q.size() < DEPTH) exp_q.push_back({bad, d});
        else exp_overrun = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic st);
        logic [10:0] f;
        f = {st, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            Sin = f[i];
            repeat (BT) @(negedge clk);
        end
    endtask

    task automatic frame(input logic [7:0] d, input logic p, input logic st);
        expect_frame(d, p, st);
        send_frame(d, p, st);
    endtask

    task automatic drain();
        ack_en = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    always begin
        @(negedge clk);
        #2;
        if (framingErr) fe_count++;
        if (Receive && Received) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte: got 0x%0h, expected none", {parityErr, Dout});
            end else begin
                check("rx_byte", {parityErr, Dout}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       p, st;
        int         gap;
        repeat (3) @(negedge clk);
        check("rst_receive", Receive, 0);
        check("rst_dout", Dout, 0);
        check("rst_parity", parityErr, 0);
        check("rst_framing", framingErr, 0);
        check("rst_overrun", overrun, 0);
        Reset = 1'b0;
        repeat (5) @(negedge clk);

        expect_frame(8'h30, 1'b1, 1'b1);
        fork
            send_frame(8'h30, 1'b1, 1'b1);
            begin
                repeat (170) @(posedge clk);
                @(negedge clk);
                check("rx_before_push", Receive, 0);
                @(negedge clk);
                check("rx_latency", Receive, 1);
            end
        join
        ack_en = 1'b1;
        @(negedge clk);
        ack_en = 1'b0;
        check("rx_pop_fall", Receive, 0);
        check("rx_pop_queue", exp_q.size(), 0);

        frame(8'h39, good_par(8'h39), 1'b1);
        for (int i = 1; i <= 4; i++) frame(8'(i), good_par(8'(i)), 1'b1);
        check("burst_overrun", overrun, exp_overrun);
        check("burst_overrun_model", exp_overrun, 1);
        check("burst_receive", Receive, 1);
        drain();
        check("burst_drained", Receive, 0);

        frame(8'h40, 1'b1, 1'b1);
        drain();

        ack_en = 1'b0;
        frame(8'h31, good_par(8'h31), 1'b0);
        repeat (40) @(negedge clk);
        check("framing_pulses", fe_count, exp_fe);
        check("framing_nopush", Receive, 0);
        Sin = 1'b1;
        repeat (8) @(negedge clk);
        frame(8'h32, good_par(8'h32), 1'b1);
        drain();

        ack_en = 1'b0;
        Sin = 1'b0;
        repeat (3) @(negedge clk);
        Sin = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_nopush", Receive, 0);
        check("glitch_framing", fe_count, exp_fe);
        check("glitch_overrun", overrun, exp_overrun);

        frame(8'h33, good_par(8'h33), 1'b1);
        check("midrst_buffered", Receive, 1);
        d = 8'h55;
        Sin = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            Sin = d[i];
            repeat (BT) @(negedge clk);
        end
        Sin = d[4];
        repeat (BT / 2) @(negedge clk);
        Reset = 1'b1;
        Sin = 1'b1;
        exp_q.delete();
        exp_overrun = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_receive", Receive, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_framing", framingErr, 0);
        Reset = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_idle", Receive, 0);
        ack_en = 1'b1;
        frame(8'h34, good_par(8'h34), 1'b1);
        drain();

        for (int n = 0; n < 30; n++) begin
            ack_en = $urandom_range(0, 3) != 0;
            d = 8'($urandom);
            p = good_par(d) ^ ($urandom_range(0, 3) == 0);
            st = $urandom_range(0, 7) != 0;
            frame(d, p, st);
            gap = st ? $urandom_range(0, 12) : 8 + $urandom_range(0, 12);
            Sin = 1'b1;
            repeat (gap) @(negedge clk);
        end
        drain();
        check("rand_receive", Receive, 0);
        check("rand_overrun", overrun, exp_overrun);
        check("rand_framing", fe_count, exp_fe);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
